mtm_alu_serializer: RTL and testbench

Output-side serializer for the MTM ALU. It accepts one parallel result (32-bit C plus 4 status flags) or one error report per transaction. It emits that transaction on a single serial line using the same bit-level frame format the ALU input deserializer receives. Result packets carry a CRC-3 computed inside the block; error packets carry a parity bit. The block sits between the ALU core and the chip-level `sout` pin.

---
 rtl/mtm_Alu_pkg.sv | 28 ++
 rtl/mtm_Alu_crc3.sv | 23 ++
 rtl/mtm_alu_serializer.sv | 127 ++++++++++++
 tb/tb_mtm_alu_serializer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mtm_Alu_pkg.sv
// Shared constants for the MTM ALU serial output path: FSM encodings,
// frame type bits, the CRC-3 polynomial and the result packet length.
package mtm_Alu_pkg;

  // Gray-coded so that each step along the frame sequence flips one bit.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_START = 3'b001,
    ST_TYPE  = 3'b011,
    ST_DATA  = 3'b010,
    ST_STOP  = 3'b110
  } state_t;

  localparam logic       FRAME_DATA = 1'b0;
  localparam logic       FRAME_CTL  = 1'b1;
  localparam logic [2:0] CRC3_POLY  = 3'b011;
  localparam logic [2:0] RES_FRAMES = 3'd5;
  localparam int         CRC_IN_W   = 37;

  // Error byte duplicates each flag, so the trailing even-parity bit
  // always comes out as 1; it is still computed to keep the intent visible.
  function automatic logic [7:0] err_byte(input logic [2:0] e);
    logic [6:0] hi;
    hi = {1'b1, e[2], e[2], e[1], e[1], e[0], e[0]};
    return {hi, ^hi};
  endfunction

endpackage

// File: rtl/mtm_Alu_crc3.sv
// Combinational CRC-3 (x^3+x+1, init 0, no final XOR) over a 37-bit word,
// MSB first. Shared with the ALU core for its reference checks.
module mtm_Alu_crc3
  import mtm_Alu_pkg::*;
(
  input  logic [CRC_IN_W-1:0] data,
  output logic [2:0]          crc
);

  logic [2:0] acc;
  logic       fb;

  always_comb begin
    acc = 3'b000;
    fb  = 1'b0;
    for (int i = CRC_IN_W - 1; i >= 0; i--) begin
      fb  = acc[2] ^ data[i];
      acc = {acc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
    end
    crc = acc;
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Serializes one ALU result (4 data frames + control frame with CRC-3) or
// one error report (single control frame) onto sout, 11-bit frames.
//
// state | meaning
// IDLE  | line high, waiting for res_valid / err_valid
// START | start bit 0
// TYPE  | frame type bit (data / control)
// DATA  | 8 payload bits, MSB first, bit_cnt 7 -> 0
// STOP  | stop bit 1, then next frame or back to IDLE
module mtm_alu_serializer
  import mtm_Alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  input  logic [31:0] C_in,
  input  logic [3:0]  flags_in,
  input  logic        err_valid,
  input  logic [2:0]  err_flags,
  output logic        sout,
  output logic        busy
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] c_q;
  logic [3:0]  flags_q;
  logic [2:0]  err_q;
  logic        is_err_q;
  logic [2:0]  bit_cnt;
  logic [2:0]  frame_cnt;
  logic [2:0]  crc;
  logic [7:0]  byte_sel;
  logic        sout_d;
  logic        busy_d;
  logic        accept;

  mtm_Alu_crc3 u_crc3 (
    .data ({c_q, 1'b0, flags_q}),
    .crc  (crc)
  );

  // The busy register lags the FSM by one cycle, so both must show idle.
  assign accept = (state == ST_IDLE) && !busy && (res_valid || err_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      sout  <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      sout  <= sout_d;
      busy  <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q       <= '0;
      flags_q   <= '0;
      err_q     <= '0;
      is_err_q  <= 1'b0;
      frame_cnt <= '0;
      bit_cnt   <= '0;
    end else begin
      if (accept) begin
        is_err_q <= err_valid;
        if (err_valid) begin
          err_q     <= err_flags;
          frame_cnt <= 3'd0;
        end else begin
          c_q       <= C_in;
          flags_q   <= flags_in;
          frame_cnt <= RES_FRAMES - 3'd1;
        end
      end else if (state == ST_STOP && frame_cnt != 3'd0) begin
        frame_cnt <= frame_cnt - 3'd1;
      end
      if (state == ST_TYPE) begin
        bit_cnt <= 3'd7;
      end else if (state == ST_DATA) begin
        bit_cnt <= bit_cnt - 3'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_START;
      ST_START: state_nx = ST_TYPE;
      ST_TYPE:  state_nx = ST_DATA;
      ST_DATA:  if (bit_cnt == 3'd0) state_nx = ST_STOP;
      ST_STOP:  state_nx = (frame_cnt != 3'd0) ? ST_START : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // frame_cnt counts remaining frames; zero always means the control frame.
  always_comb begin
    byte_sel = 8'h00;
    if (is_err_q) begin
      byte_sel = err_byte(err_q);
    end else begin
      case (frame_cnt)
        3'd4:    byte_sel = c_q[31:24];
        3'd3:    byte_sel = c_q[23:16];
        3'd2:    byte_sel = c_q[15:8];
        3'd1:    byte_sel = c_q[7:0];
        default: byte_sel = {1'b0, flags_q, crc};
      endcase
    end
  end

  always_comb begin
    sout_d = 1'b1;
    busy_d = (state != ST_IDLE);
    case (state)
      ST_START: sout_d = 1'b0;
      ST_TYPE:  sout_d = (frame_cnt == 3'd0) ? FRAME_CTL : FRAME_DATA;
      ST_DATA:  sout_d = byte_sel[bit_cnt];
      default:  sout_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench for mtm_alu_serializer: decodes sout frame by frame and
// compares against hand-computed bytes and a long-division CRC-3 model.
module tb_mtm_alu_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] C_in = '0;
  logic [3:0]  flags_in = '0;
  logic        err_valid = 1'b0;
  logic [2:0]  err_flags = '0;
  logic        sout;
  logic        busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [10:0] frm [5];
  int          busy_low;
  int          bad;

  always #5 clk = ~clk;

  mtm_alu_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .C_in      (C_in),
    .flags_in  (flags_in),
    .err_valid (err_valid),
    .err_flags (err_flags),
    .sout      (sout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic t, input logic [7:0] b);
    return {1'b0, t, b, 1'b1};
  endfunction

  // Remainder of M(x)*x^3 mod (x^3+x+1).
  function automatic logic [2:0] crc_ref(input logic [36:0] m);
    logic [39:0] r;
    r = {m, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  // Called just after the accept edge; samples nfr frames then one idle cycle.
  task automatic recv(input int nfr, input int pulse_at);
    busy_low = 0;
    for (int f = 0; f < nfr; f++) begin
      frm[f] = '0;
      for (int b = 0; b < 11; b++) begin
        @(posedge clk); #1;
        frm[f] = {frm[f][9:0], sout};
        if (!busy) busy_low++;
        res_valid = (f * 11 + b + 1 == pulse_at);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_busy_held"}, busy_low, 0);
    check({tag, "_busy_fall"}, busy, 1'b0);
    check({tag, "_sout_idle"}, sout, 1'b1);
  endtask

  task automatic send_res(input logic [31:0] c, input logic [3:0] fl, input string tag);
    C_in = c;
    flags_in = fl;
    res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    C_in = ~c;
    flags_in = ~fl;
    recv(5, 0);
    check({tag, "_b3"}, frm[0], frame(1'b0, c[31:24]));
    check({tag, "_b2"}, frm[1], frame(1'b0, c[23:16]));
    check({tag, "_b1"}, frm[2], frame(1'b0, c[15:8]));
    check({tag, "_b0"}, frm[3], frame(1'b0, c[7:0]));
    check({tag, "_ctl"}, frm[4], frame(1'b1, {1'b0, fl, crc_ref({c, 1'b0, fl})}));
    end_checks(tag);
  endtask

  task automatic send_err(input logic [2:0] e, input logic [7:0] exp_byte, input string tag);
    err_flags = e;
    err_valid = 1'b1;
    @(posedge clk); #1;
    err_valid = 1'b0;
    err_flags = ~e;
    recv(1, 0);
    check({tag, "_frame"}, frm[0], frame(1'b1, exp_byte));
    end_checks(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_sout", sout, 1'b1);
    check("rst_busy", busy, 1'b0);
    @(negedge clk) rst = 1'b1;

    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (sout !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle20", bad, 0);

    send_res(32'h0000_0000, 4'b0000, "res_zero");
    check("zero_ctl_byte", frm[4], 11'b0_1_00000000_1);
    send_res(32'h1234_5678, 4'b0001, "res_1234");
    send_res(32'hFFFF_FFFF, 4'b1111, "res_ones");

    send_err(3'b100, 8'hE1, "err_crc");
    send_err(3'b010, 8'h99, "err_op");
    send_err(3'b001, 8'h87, "err_data");
    send_err(3'b111, 8'hFF, "err_all");

    // Both valids together, then a stray res_valid mid-packet.
    C_in = 32'hDEAD_BEEF;
    flags_in = 4'b0110;
    err_flags = 3'b010;
    res_valid = 1'b1;
    err_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    err_valid = 1'b0;
    recv(1, 5);
    check("both_frame", frm[0], frame(1'b1, 8'h99));
    end_checks("both");
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (sout !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("both_no_result", bad, 0);

    // Reset in the middle of a result packet.
    C_in = 32'hA5C3_0F01;
    flags_in = 4'b1010;
    res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_sout", sout, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_sout", sout, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    send_res(32'hA5C3_0F01, 4'b1010, "res_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
